// File: rtl/coherence_arbiter.sv
// coherence_arbiter: arbitrates per-CPU icache/dcache requests onto a single RAM
// port and runs MSI snooping (snoop broadcast, invalidate, cache-to-cache transfer
// with RAM writeback of a Modified block).
// Build option: define COHERENCE_ARB_RR_EN for round-robin arbitration across CPUs;
// left undefined, the lowest CPU index with a request always wins.

package coherence_arbiter_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module coherence_arbiter
  import coherence_arbiter_pkg::*;
#(
  parameter int CPUS      = 2,
  parameter int BLK_WORDS = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [CPUS-1:0]    iREN,
  input  logic [CPUS*32-1:0] iaddr,
  output logic [CPUS-1:0]    iwait,
  output logic [CPUS*32-1:0] iload,
  input  logic [CPUS-1:0]    dREN,
  input  logic [CPUS-1:0]    dWEN,
  input  logic [CPUS*32-1:0] daddr,
  input  logic [CPUS*32-1:0] dstore,
  output logic [CPUS-1:0]    dwait,
  output logic [CPUS*32-1:0] dload,
  input  logic [CPUS-1:0]    ccwrite,
  input  logic [CPUS-1:0]    cctrans,
  output logic [CPUS-1:0]    ccwait,
  output logic [CPUS-1:0]    ccinv,
  output logic [CPUS*32-1:0] ccsnoopaddr,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [31:0]        ramaddr,
  output logic [31:0]        ramstore,
  input  logic [31:0]        ramload,
  input  ramstate_t          ramstate
);
  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(BLK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, IFETCH, DWB, SNOOP, C2C, DREAD} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] snoop_q, snoop_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] pick;
  logic [CPUS-1:0] req;
  logic          access;
  logic          all_trans;
  int            gi, si;
  logic [31:0]   iaddr_a  [CPUS];
  logic [31:0]   daddr_a  [CPUS];
  logic [31:0]   dstore_a [CPUS];

  for (genvar c = 0; c < CPUS; c++) begin : g_unpack
    assign iaddr_a[c]  = iaddr[c*32 +: 32];
    assign daddr_a[c]  = daddr[c*32 +: 32];
    assign dstore_a[c] = dstore[c*32 +: 32];
  end

  assign req    = iREN | dREN | dWEN;
  assign access = (ramstate == ACCESS);
  assign gi     = int'(grant_q);
  assign si     = int'(snoop_q);

`ifdef COHERENCE_ARB_RR_EN
  logic [GW-1:0] last_q, last_d;
  logic          found;

  // Round-robin search beginning one past the previous grant.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < CPUS; k++) begin
      if (!found && req[(int'(last_q) + 1 + k) % CPUS]) begin
        pick  = GW'((int'(last_q) + 1 + k) % CPUS);
        found = 1'b1;
      end
    end
  end

  assign last_d = (state_q == IDLE && |req) ? pick : last_q;

  // Last-grant pointer; resets so that CPU0 is searched first.
  always_ff @(posedge CLK) begin
    if (RST) last_q <= GW'(CPUS - 1);
    else     last_q <= last_d;
  end
`else
  // Fixed priority: lowest CPU index with any request wins.
  always_comb begin
    pick = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (req[k]) pick = GW'(k);
    end
  end
`endif

  // Next-state and output decode for the transaction FSM.
  always_comb begin
    // NOTE: every next-state value and output is defaulted first so no latch can be inferred.
    state_d     = state_q;
    grant_d     = grant_q;
    snoop_d     = snoop_q;
    count_d     = count_q;
    all_trans   = 1'b1;
    iwait       = '1;
    dwait       = '1;
    iload       = '0;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (|req) begin
          grant_d = pick;
          if (dWEN[pick])      state_d = DWB;
          else if (dREN[pick]) state_d = SNOOP;
          else                 state_d = IFETCH;
        end
      end
      IFETCH: begin
        ramREN              = 1'b1;
        ramaddr             = iaddr_a[gi];
        iload[gi*32 +: 32]  = ramload;
        if (access) begin
          iwait[gi] = 1'b0;
          state_d   = IDLE;
        end
      end
      DWB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr_a[gi];
        ramstore = dstore_a[gi];
        if (access) begin
          dwait[gi] = 1'b0;
          if (count_q == LAST_WORD || !dWEN[gi]) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      SNOOP: begin
        for (int j = 0; j < CPUS; j++) begin
          if (j != gi) begin
            ccwait[j]               = 1'b1;
            ccsnoopaddr[j*32 +: 32] = daddr_a[gi];
            ccinv[j]                = ccwrite[gi];
            if (!cctrans[j]) all_trans = 1'b0;
          end
        end
        if (all_trans) begin
          state_d = DREAD;
          // Descending scan so the lowest Modified holder is the one latched.
          for (int j = CPUS - 1; j >= 0; j--) begin
            if (j != gi && ccwrite[j]) begin
              snoop_d = GW'(j);
              state_d = C2C;
            end
          end
        end
      end
      C2C: begin
        ccwait[si]               = 1'b1;
        ccsnoopaddr[si*32 +: 32] = daddr_a[gi];
        ccinv[si]                = ccwrite[gi];
        ramWEN                   = 1'b1;
        ramaddr                  = daddr_a[gi];
        ramstore                 = dstore_a[si];
        dload[gi*32 +: 32]       = dstore_a[si];
        if (access) begin
          dwait[gi] = 1'b0;
          dwait[si] = 1'b0;
          if (count_q == LAST_WORD || !dREN[gi]) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      DREAD: begin
        ramREN             = 1'b1;
        ramaddr            = daddr_a[gi];
        dload[gi*32 +: 32] = ramload;
        if (access) begin
          dwait[gi] = 1'b0;
          if (count_q == LAST_WORD || !dREN[gi]) begin
            state_d = IDLE;
            count_d = '0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, snooper and word-count registers.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      snoop_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      snoop_q <= snoop_d;
      count_q <= count_d;
    end
  end

endmodule
